// File: rtl/pingpong_capture_buffer_if.sv
// Sample-producer / frame-reader bus of the ping-pong capture buffer.
// The master drives samples, trigger, ack and read requests; the slave is the buffer.
interface pingpong_capture_buffer_if #(
  parameter int SAMPLE_SIZE = 12,
  parameter int CHANNELS    = 2,
  parameter int ADDR_W      = 10,
  parameter int OVR_W       = 8
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                            ready;
  logic [CHANNELS*SAMPLE_SIZE-1:0] dataIN;
  logic                            trigIn;
  logic                            frame_ack;
  logic                            rdEn;
  logic [CH_W-1:0]                 rdChan;
  logic signed [ADDR_W-1:0]        rdOffset;
  logic signed [SAMPLE_SIZE-1:0]   dataOut;
  logic                            dataOutValid;
  logic                            frame_valid;
  logic                            activeBank;
  logic [ADDR_W-1:0]               trigAddr;
  logic [OVR_W-1:0]                overrunCnt;

  modport master (
    output ready, dataIN, trigIn, frame_ack, rdEn, rdChan, rdOffset,
    input  dataOut, dataOutValid, frame_valid, activeBank, trigAddr, overrunCnt
  );

  modport slave (
    input  ready, dataIN, trigIn, frame_ack, rdEn, rdChan, rdOffset,
    output dataOut, dataOutValid, frame_valid, activeBank, trigAddr, overrunCnt
  );
endinterface

// File: rtl/pingpong_capture_buffer.sv
// Two-bank capture buffer: the active bank records a pre/post-trigger window
// while the locked bank serves trigger-relative reads until acknowledged.
module pingpong_capture_buffer #(
  parameter int SAMPLE_SIZE = 12,
  parameter int CHANNELS    = 2,
  parameter int ADDR_W      = 10,
  parameter int POST_TRIG   = 512,
  parameter int OVR_W       = 8
) (
  input logic                      CLK104MHZ,
  input logic                      rst,
  pingpong_capture_buffer_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DW    = CHANNELS * SAMPLE_SIZE;
  localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(DEPTH - POST_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_TRIG - 1);

  typedef enum logic [1:0] {S_PRIME, S_ARMED, S_POST} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] cap_trig_q, cap_trig_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              active_bank_q, active_bank_d;
  logic              frame_valid_q, frame_valid_d;
  logic [OVR_W-1:0]  overrun_q, overrun_d;

  logic              post_wr, cap_done, bank_free;
  logic [ADDR_W-1:0] cap_trig_cur, post_cur;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    fill_cnt_d    = fill_cnt_q;
    post_cnt_d    = post_cnt_q;
    cap_trig_d    = cap_trig_q;
    trig_addr_d   = trig_addr_q;
    active_bank_d = active_bank_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = overrun_q;
    post_wr       = 1'b0;
    cap_done      = 1'b0;
    cap_trig_cur  = cap_trig_q;
    post_cur      = post_cnt_q;
    bank_free     = !frame_valid_q || bus.frame_ack;

    if (bus.ready) wr_ptr_d = wr_ptr_q + ADDR_W'(1);

    unique case (state_q)
      S_PRIME: begin
        if (bus.ready) begin
          fill_cnt_d = fill_cnt_q + ADDR_W'(1);
          if (fill_cnt_q == FILL_LAST) state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        // A sample arriving with the trigger is already the first post sample.
        if (bus.trigIn) begin
          cap_trig_cur = wr_ptr_q;
          cap_trig_d   = wr_ptr_q;
          post_cur     = '0;
          post_cnt_d   = '0;
          post_wr      = bus.ready;
          state_d      = S_POST;
        end
      end
      S_POST:  post_wr = bus.ready;
      default: state_d = S_PRIME;
    endcase

    if (post_wr) begin
      post_cnt_d = post_cur + ADDR_W'(1);
      cap_done   = (post_cur == POST_LAST);
    end

    if (cap_done) begin
      post_cnt_d = '0;
      if (bank_free) begin
        active_bank_d = ~active_bank_q;
        trig_addr_d   = cap_trig_cur;
        wr_ptr_d      = '0;
        fill_cnt_d    = '0;
        state_d       = S_PRIME;
      end else begin
        if (overrun_q != '1) overrun_d = overrun_q + OVR_W'(1);
        state_d = S_ARMED;
      end
    end

    if (cap_done && bank_free) frame_valid_d = 1'b1;
    else if (bus.frame_ack)    frame_valid_d = 1'b0;
  end

  always_ff @(posedge CLK104MHZ) begin
    if (rst) begin
      state_q       <= S_PRIME;
      wr_ptr_q      <= '0;
      fill_cnt_q    <= '0;
      post_cnt_q    <= '0;
      cap_trig_q    <= '0;
      trig_addr_q   <= '0;
      active_bank_q <= 1'b0;
      frame_valid_q <= 1'b0;
      overrun_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      fill_cnt_q    <= fill_cnt_d;
      post_cnt_q    <= post_cnt_d;
      cap_trig_q    <= cap_trig_d;
      trig_addr_q   <= trig_addr_d;
      active_bank_q <= active_bank_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  logic [DW-1:0]     bank0_mem [DEPTH];
  logic [DW-1:0]     bank1_mem [DEPTH];
  logic [DW-1:0]     rd_word0_q, rd_word1_q;
  logic [ADDR_W-1:0] rd_addr;

  assign rd_addr = trig_addr_q + $unsigned(bus.rdOffset);

  always_ff @(posedge CLK104MHZ) begin
    if (bus.ready && !rst && !active_bank_q) bank0_mem[wr_ptr_q] <= bus.dataIN;
    if (bus.rdEn) rd_word0_q <= bank0_mem[rd_addr];
  end

  always_ff @(posedge CLK104MHZ) begin
    if (bus.ready && !rst && active_bank_q) bank1_mem[wr_ptr_q] <= bus.dataIN;
    if (bus.rdEn) rd_word1_q <= bank1_mem[rd_addr];
  end

  logic [CH_W-1:0]        rd_chan_q, rd_chan_d;
  logic                   rd_bank_q, rd_bank_d;
  logic                   rd_vld1_q, rd_vld1_d;
  logic [SAMPLE_SIZE-1:0] data_out_q, data_out_d;
  logic                   data_out_vld_q, data_out_vld_d;
  logic [DW-1:0]          rd_word;
  logic [SAMPLE_SIZE-1:0] rd_slice;

  always_comb begin
    rd_chan_d      = bus.rdEn ? bus.rdChan : rd_chan_q;
    rd_bank_d      = bus.rdEn ? ~active_bank_q : rd_bank_q;
    rd_vld1_d      = bus.rdEn;
    rd_word        = rd_bank_q ? rd_word1_q : rd_word0_q;
    rd_slice       = rd_word[SAMPLE_SIZE-1:0];
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (rd_chan_q == CH_W'(c)) rd_slice = rd_word[c*SAMPLE_SIZE +: SAMPLE_SIZE];
    end
    data_out_d     = rd_vld1_q ? rd_slice : data_out_q;
    data_out_vld_d = rd_vld1_q;
  end

  always_ff @(posedge CLK104MHZ) begin
    if (rst) begin
      rd_chan_q      <= '0;
      rd_bank_q      <= 1'b0;
      rd_vld1_q      <= 1'b0;
      data_out_q     <= '0;
      data_out_vld_q <= 1'b0;
    end else begin
      rd_chan_q      <= rd_chan_d;
      rd_bank_q      <= rd_bank_d;
      rd_vld1_q      <= rd_vld1_d;
      data_out_q     <= data_out_d;
      data_out_vld_q <= data_out_vld_d;
    end
  end

  assign bus.dataOut      = data_out_q;
  assign bus.dataOutValid = data_out_vld_q;
  assign bus.frame_valid  = frame_valid_q;
  assign bus.activeBank   = active_bank_q;
  assign bus.trigAddr     = trig_addr_q;
  assign bus.overrunCnt   = overrun_q;
endmodule

// File: tb/tb_pingpong_capture_buffer.sv
// Scenario bench for the ping-pong capture buffer (16-deep banks, 4 post samples).
// Sample n carries ch0=n, ch1=100+n; read expectations travel through a queue.
module tb_pingpong_capture_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pingpong_capture_buffer_if #(.SAMPLE_SIZE(12), .CHANNELS(2), .ADDR_W(4), .OVR_W(8)) bus();

  pingpong_capture_buffer #(
    .SAMPLE_SIZE(12), .CHANNELS(2), .ADDR_W(4), .POST_TRIG(4), .OVR_W(8)
  ) dut (
    .CLK104MHZ(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { logic [11:0] data; int due; } rd_exp_t;
  rd_exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int n = 0;
  int r = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input logic rdy, input logic trig, input logic ack);
    bus.ready     = rdy;
    bus.trigIn    = trig;
    bus.frame_ack = ack;
    bus.dataIN    = {12'(100 + n), 12'(n)};
    @(posedge clk);
    #1;
    if (rdy) n++;
    bus.ready = 1'b0; bus.trigIn = 1'b0; bus.frame_ack = 1'b0; bus.rdEn = 1'b0;
  endtask

  task automatic issue_read(input int chan, input int off, input int exp_val);
    rd_exp_t e;
    bus.rdEn     = 1'b1;
    bus.rdChan   = 1'(chan);
    bus.rdOffset = 4'(off);
    e.data = 12'(exp_val);
    e.due  = cyc + 2;
    exp_q.push_back(e);
  endtask

  task automatic sparse(input logic trig);
    tick(1'b1, trig, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
  endtask

  // Read-data monitor: every valid beat must match the oldest outstanding read.
  initial begin
    rd_exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (bus.dataOutValid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected dataOutValid with no read pending at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          if (bus.dataOut !== e.data || cyc != e.due) begin
            failures++;
            $display("FAIL rd_data got=%0d at cycle %0d want=%0d at cycle %0d",
                     bus.dataOut, cyc, e.data, e.due);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.frame_valid !== 1'b0 || bus.activeBank !== 1'b0 || bus.trigAddr !== 4'd0 ||
        bus.overrunCnt !== 8'd0 || bus.dataOutValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got fv=%0b ab=%0b ta=%0d ovr=%0d dv=%0b want all 0",
               bus.frame_valid, bus.activeBank, bus.trigAddr, bus.overrunCnt, bus.dataOutValid);
    end
    rst = 1'b0;
  endtask

  task automatic test_prime();
    for (int i = 0; i < 11; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      checks++;
      if (bus.frame_valid !== 1'b0 || bus.trigAddr !== 4'd0) begin
        failures++;
        $display("FAIL prime_ignore_trig sample=%0d got fv=%0b ta=%0d want fv=0 ta=0",
                 n - 1, bus.frame_valid, bus.trigAddr);
      end
    end
    tick(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_capture();
    while (n < 20) tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL capture_early fv got=%0b want=0 before last post sample", bus.frame_valid);
    end
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.activeBank !== 1'b1 || bus.trigAddr !== 4'd4) begin
      failures++;
      $display("FAIL capture_frame got fv=%0b ab=%0b ta=%0d want fv=1 ab=1 ta=4",
               bus.frame_valid, bus.activeBank, bus.trigAddr);
    end
    issue_read(0, 0, 20);    tick(1'b1, 1'b0, 1'b0);
    issue_read(0, -12, 8);   tick(1'b1, 1'b0, 1'b0);
    issue_read(1, 3, 123);   tick(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_overrun();
    while (n < 36) tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.overrunCnt !== 8'd0) begin
      failures++;
      $display("FAIL overrun_early got=%0d want=0", bus.overrunCnt);
    end
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.overrunCnt !== 8'd1 || bus.frame_valid !== 1'b1 || bus.activeBank !== 1'b1 ||
        bus.trigAddr !== 4'd4) begin
      failures++;
      $display("FAIL overrun_state got ovr=%0d fv=%0b ab=%0b ta=%0d want ovr=1 fv=1 ab=1 ta=4",
               bus.overrunCnt, bus.frame_valid, bus.activeBank, bus.trigAddr);
    end
    issue_read(0, 0, 20);    tick(1'b1, 1'b0, 1'b0);
    issue_read(1, -12, 108); tick(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_ack_swap();
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    checks++;
    if (bus.activeBank !== 1'b0 || bus.frame_valid !== 1'b1 || bus.trigAddr !== 4'd2 ||
        bus.overrunCnt !== 8'd1) begin
      failures++;
      $display("FAIL ack_swap got ab=%0b fv=%0b ta=%0d ovr=%0d want ab=0 fv=1 ta=2 ovr=1",
               bus.activeBank, bus.frame_valid, bus.trigAddr, bus.overrunCnt);
    end
    issue_read(0, 0, 42);    tick(1'b1, 1'b0, 1'b0);
    issue_read(0, -12, 30);  tick(1'b1, 1'b0, 1'b0);
    issue_read(1, 3, 145);   tick(1'b1, 1'b0, 1'b0);
    issue_read(1, -1, 141);  tick(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_ack_release();
    tick(1'b1, 1'b0, 1'b1);
    checks++;
    if (bus.frame_valid !== 1'b0 || bus.activeBank !== 1'b0 || bus.trigAddr !== 4'd2) begin
      failures++;
      $display("FAIL ack_release got fv=%0b ab=%0b ta=%0d want fv=0 ab=0 ta=2",
               bus.frame_valid, bus.activeBank, bus.trigAddr);
    end
    while (n < 58) tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.activeBank !== 1'b1 || bus.trigAddr !== 4'd12 ||
        bus.overrunCnt !== 8'd1) begin
      failures++;
      $display("FAIL free_swap got fv=%0b ab=%0b ta=%0d ovr=%0d want fv=1 ab=1 ta=12 ovr=1",
               bus.frame_valid, bus.activeBank, bus.trigAddr, bus.overrunCnt);
    end
    issue_read(0, 0, 58);    tick(1'b1, 1'b0, 1'b0);
    issue_read(1, 3, 161);   tick(1'b1, 1'b0, 1'b0);
    issue_read(0, -12, 46);  tick(1'b1, 1'b0, 1'b0);
    issue_read(0, -1, 57);   tick(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_overrun_saturate();
    while (n < 74) tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 254; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      repeat (3) tick(1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (bus.overrunCnt !== 8'd255) begin
      failures++;
      $display("FAIL overrun_max got=%0d want=255", bus.overrunCnt);
    end
    tick(1'b1, 1'b1, 1'b0);
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.overrunCnt !== 8'd255 || bus.frame_valid !== 1'b1 || bus.trigAddr !== 4'd12) begin
      failures++;
      $display("FAIL overrun_saturate got ovr=%0d fv=%0b ta=%0d want ovr=255 fv=1 ta=12",
               bus.overrunCnt, bus.frame_valid, bus.trigAddr);
    end
    issue_read(0, 0, 58);    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_post();
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    checks++;
    if (bus.frame_valid !== 1'b0 || bus.activeBank !== 1'b0 || bus.overrunCnt !== 8'd0 ||
        bus.trigAddr !== 4'd0 || bus.dataOutValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_post got fv=%0b ab=%0b ovr=%0d ta=%0d dv=%0b want all 0",
               bus.frame_valid, bus.activeBank, bus.overrunCnt, bus.trigAddr, bus.dataOutValid);
    end
    r = n;
    for (int i = 0; i < 11; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      checks++;
      if (bus.frame_valid !== 1'b0) begin
        failures++;
        $display("FAIL reprime_ignore_trig rel=%0d fv got=%0b want=0", i, bus.frame_valid);
      end
    end
  endtask

  task automatic test_sparse();
    tick(1'b1, 1'b0, 1'b0);
    sparse(1'b0);
    sparse(1'b0);
    sparse(1'b1);
    sparse(1'b0);
    sparse(1'b0);
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL sparse_early fv got=%0b want=0 after 3 post strobes", bus.frame_valid);
    end
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.activeBank !== 1'b1 || bus.trigAddr !== 4'd14) begin
      failures++;
      $display("FAIL sparse_frame got fv=%0b ab=%0b ta=%0d want fv=1 ab=1 ta=14",
               bus.frame_valid, bus.activeBank, bus.trigAddr);
    end
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    issue_read(0, 0, r + 14);         tick(1'b0, 1'b0, 1'b0);
    issue_read(0, -12, r + 2);        tick(1'b0, 1'b0, 1'b0);
    issue_read(1, 3, 100 + r + 17);   tick(1'b0, 1'b0, 1'b0);
    repeat (4) tick(1'b0, 1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rd_missing pending reads got=%0d want=0", exp_q.size());
    end
  endtask

  initial begin
    bus.ready = 1'b0; bus.dataIN = '0; bus.trigIn = 1'b0; bus.frame_ack = 1'b0;
    bus.rdEn = 1'b0; bus.rdChan = '0; bus.rdOffset = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_prime();
    test_capture();
    test_overrun();
    test_ack_swap();
    test_ack_release();
    test_overrun_saturate();
    test_reset_mid_post();
    test_sparse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
